// File: rtl/branch_predictor_btb_pkg.sv
// Shared encodings and helpers for the branch target buffer: 2-bit direction
// counter states, saturating counter steps and PC index/tag slicing.
package branch_predictor_btb_pkg;

  // Direction counter encoding: bit 1 is the predicted direction.
  localparam logic [1:0] SNT = 2'b00;
  localparam logic [1:0] WNT = 2'b01;
  localparam logic [1:0] WT  = 2'b10;
  localparam logic [1:0] ST  = 2'b11;

  // Saturating increment towards strong-taken.
  function automatic logic [1:0] ctr_inc(input logic [1:0] c);
    return (c == ST) ? ST : c + 2'd1;
  endfunction

  // Saturating decrement towards strong-not-taken.
  function automatic logic [1:0] ctr_dec(input logic [1:0] c);
    return (c == SNT) ? SNT : c - 2'd1;
  endfunction

  // Entry index: pc[idx_w+1:2]. Callers pass the PC zero-extended to 64 bits
  // and cast the result down to their index width.
  function automatic logic [63:0] pc_index(input logic [63:0] pc, input int idx_w);
    return (pc >> 2) & ((64'd1 << idx_w) - 64'd1);
  endfunction

  // Entry tag: everything above the index bits.
  function automatic logic [63:0] pc_tag(input logic [63:0] pc, input int idx_w);
    return pc >> (idx_w + 2);
  endfunction

endpackage

// File: rtl/branch_predictor_btb_entry_array.sv
// BTB storage: per-entry valid/tag/target/counter. Two combinational read
// ports (fetch lookup and the update side's read-modify-write) and one
// synchronous write port. Flush clears valid bits and beats any write.
module branch_predictor_btb_entry_array
  import branch_predictor_btb_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int ENTRIES = 16,
  parameter int IDX_W   = $clog2(ENTRIES),
  parameter int TAG_W   = XLEN - IDX_W - 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic [IDX_W-1:0] rd_idx,
  output logic             rd_valid,
  output logic [TAG_W-1:0] rd_tag,
  output logic [XLEN-1:0]  rd_target,
  output logic [1:0]       rd_ctr,
  input  logic [IDX_W-1:0] up_idx,
  output logic             up_valid,
  output logic [TAG_W-1:0] up_tag,
  output logic [XLEN-1:0]  up_target,
  output logic [1:0]       up_ctr,
  input  logic             wr_en,
  input  logic [TAG_W-1:0] wr_tag,
  input  logic [XLEN-1:0]  wr_target,
  input  logic [1:0]       wr_ctr
);

  logic             valid_reg  [ENTRIES];
  logic [1:0]       ctr_reg    [ENTRIES];
  logic [TAG_W-1:0] tag_mem    [ENTRIES];
  logic [XLEN-1:0]  target_mem [ENTRIES];

  genvar gi;
  generate
    for (gi = 0; gi < ENTRIES; gi++) begin : g_entry
      // Valid bit and counter: async reset to invalid/weak-NT, flush wins over write.
      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          valid_reg[gi] <= 1'b0;
          ctr_reg[gi]   <= WNT;
        end else if (flush) begin
          valid_reg[gi] <= 1'b0;
        end else if (wr_en && (up_idx == IDX_W'(gi))) begin
          valid_reg[gi] <= 1'b1;
          ctr_reg[gi]   <= wr_ctr;
        end
      end

      // Tag and target need no reset: they are only observed behind a valid bit.
      always_ff @(posedge clk) begin
        if (wr_en && !flush && (up_idx == IDX_W'(gi))) begin
          tag_mem[gi]    <= wr_tag;
          target_mem[gi] <= wr_target;
        end
      end
    end
  endgenerate

  // Combinational reads: pre-update contents, no write bypass.
  always_comb begin
    rd_valid  = valid_reg[rd_idx];
    rd_tag    = tag_mem[rd_idx];
    rd_target = target_mem[rd_idx];
    rd_ctr    = ctr_reg[rd_idx];
    up_valid  = valid_reg[up_idx];
    up_tag    = tag_mem[up_idx];
    up_target = target_mem[up_idx];
    up_ctr    = ctr_reg[up_idx];
  end

endmodule

// File: rtl/branch_predictor_btb.sv
// Branch target buffer with 2-bit direction counters. Zero-latency lookup for
// the fetch PC, registered update from the resolving stage, global flush and a
// saturating mispredict counter.
module branch_predictor_btb
  import branch_predictor_btb_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int ENTRIES = 16,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [XLEN-1:0]  lookup_pc,
  output logic             pred_taken,
  output logic [XLEN-1:0]  pred_next_pc,
  input  logic             upd_valid,
  input  logic [XLEN-1:0]  upd_pc,
  input  logic             upd_taken,
  input  logic [XLEN-1:0]  upd_target,
  input  logic             upd_mispredict,
  input  logic             flush_all,
  output logic [CNT_W-1:0] mispredict_cnt
);

  localparam int IDX_W = $clog2(ENTRIES);
  localparam int TAG_W = XLEN - IDX_W - 2;

  logic [IDX_W-1:0] lk_idx, up_idx;
  logic [TAG_W-1:0] lk_tag, up_tag_in;
  logic             rd_valid, up_valid;
  logic [TAG_W-1:0] rd_tag, up_tag;
  logic [XLEN-1:0]  rd_target, up_target;
  logic [1:0]       rd_ctr, up_ctr;
  logic             lk_hit, up_hit;
  logic             wr_en;
  logic [XLEN-1:0]  wr_target;
  logic [1:0]       wr_ctr;
  logic [CNT_W-1:0] cnt_reg;

  assign lk_idx    = IDX_W'(pc_index(64'(lookup_pc), IDX_W));
  assign lk_tag    = TAG_W'(pc_tag(64'(lookup_pc), IDX_W));
  assign up_idx    = IDX_W'(pc_index(64'(upd_pc), IDX_W));
  assign up_tag_in = TAG_W'(pc_tag(64'(upd_pc), IDX_W));

  branch_predictor_btb_entry_array #(
    .XLEN    (XLEN),
    .ENTRIES (ENTRIES),
    .IDX_W   (IDX_W),
    .TAG_W   (TAG_W)
  ) u_btb_entry_array (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush_all),
    .rd_idx    (lk_idx),
    .rd_valid  (rd_valid),
    .rd_tag    (rd_tag),
    .rd_target (rd_target),
    .rd_ctr    (rd_ctr),
    .up_idx    (up_idx),
    .up_valid  (up_valid),
    .up_tag    (up_tag),
    .up_target (up_target),
    .up_ctr    (up_ctr),
    .wr_en     (wr_en),
    .wr_tag    (up_tag_in),
    .wr_target (wr_target),
    .wr_ctr    (wr_ctr)
  );

  // Fetch-side prediction: redirect only on a hit whose counter says taken.
  always_comb begin
    lk_hit       = rd_valid && (rd_tag == lk_tag);
    pred_taken   = lk_hit && rd_ctr[1];
    pred_next_pc = pred_taken ? rd_target : lookup_pc + XLEN'(4);
  end

  // Update policy: train on hits, allocate only on taken misses.
  always_comb begin
    up_hit    = up_valid && (up_tag == up_tag_in);
    wr_en     = upd_valid && (up_hit || upd_taken);
    wr_target = upd_taken ? upd_target : up_target;
    wr_ctr    = WT;
    if (up_hit) begin
      wr_ctr = upd_taken ? ctr_inc(up_ctr) : ctr_dec(up_ctr);
    end
  end

  // Mispredict counter: saturates, survives flush, cleared only by reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_reg <= '0;
    end else if (upd_valid && upd_mispredict && (cnt_reg != {CNT_W{1'b1}})) begin
      cnt_reg <= cnt_reg + CNT_W'(1);
    end
  end

  assign mispredict_cnt = cnt_reg;

endmodule

// File: tb/tb_branch_predictor_btb.sv
// Self-checking bench for branch_predictor_btb: a vector table for the main
// sequence plus hand-written saturation and mid-cycle reset sequences.
module tb_branch_predictor_btb;

  localparam int XLEN  = 32;
  localparam int CNT_W = 4;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [XLEN-1:0]  lookup_pc;
  logic             pred_taken;
  logic [XLEN-1:0]  pred_next_pc;
  logic             upd_valid;
  logic [XLEN-1:0]  upd_pc;
  logic             upd_taken;
  logic [XLEN-1:0]  upd_target;
  logic             upd_mispredict;
  logic             flush_all;
  logic [CNT_W-1:0] mispredict_cnt;

  int n_compared   = 0;
  int n_mismatched = 0;

  branch_predictor_btb #(
    .XLEN    (XLEN),
    .ENTRIES (16),
    .CNT_W   (CNT_W)
  ) dut (
    .clk            (clk),
    .reset          (rst_n),
    .lookup_pc      (lookup_pc),
    .pred_taken     (pred_taken),
    .pred_next_pc   (pred_next_pc),
    .upd_valid      (upd_valid),
    .upd_pc         (upd_pc),
    .upd_taken      (upd_taken),
    .upd_target     (upd_target),
    .upd_mispredict (upd_mispredict),
    .flush_all      (flush_all),
    .mispredict_cnt (mispredict_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    string            name;
    logic             taken;
    logic [XLEN-1:0]  next_pc;
    logic [CNT_W-1:0] cnt;
  } exp_t;

  typedef struct {
    logic [XLEN-1:0]  lk;
    logic             uv;
    logic [XLEN-1:0]  upc;
    logic             ut;
    logic [XLEN-1:0]  utgt;
    logic             umis;
    logic             fl;
    logic             e_taken;
    logic [XLEN-1:0]  e_next;
    logic [CNT_W-1:0] e_cnt;
  } vec_t;

  exp_t sb_q[$];
  vec_t vecs[$];

  task automatic drive(input logic [XLEN-1:0] lk, input logic uv, input logic [XLEN-1:0] upc,
                       input logic ut, input logic [XLEN-1:0] utgt, input logic umis,
                       input logic fl);
    lookup_pc      = lk;
    upd_valid      = uv;
    upd_pc         = upc;
    upd_taken      = ut;
    upd_target     = utgt;
    upd_mispredict = umis;
    flush_all      = fl;
  endtask

  task automatic push_exp(input string name, input logic t, input logic [XLEN-1:0] n,
                          input logic [CNT_W-1:0] c);
    exp_t e;
    e.name = name; e.taken = t; e.next_pc = n; e.cnt = c;
    sb_q.push_back(e);
  endtask

  // Pop the oldest expectation and compare it with what the DUT shows now.
  task automatic check_pop();
    exp_t e;
    if (sb_q.size() == 0) begin
      n_compared++;
      n_mismatched++;
      $display("FAIL scoreboard_empty: actual no expectation queued, required one");
      return;
    end
    e = sb_q.pop_front();
    n_compared++;
    if (pred_taken !== e.taken || pred_next_pc !== e.next_pc || mispredict_cnt !== e.cnt) begin
      n_mismatched++;
      $display("FAIL %s: actual taken=%0b next=%h cnt=%0d, required taken=%0b next=%h cnt=%0d",
               e.name, pred_taken, pred_next_pc, mispredict_cnt, e.taken, e.next_pc, e.cnt);
    end else begin
      $display("ok   %s: taken=%0b next=%h cnt=%0d", e.name, pred_taken, pred_next_pc, mispredict_cnt);
    end
  endtask

  task automatic addv(input logic [XLEN-1:0] lk, input logic uv, input logic [XLEN-1:0] upc,
                      input logic ut, input logic [XLEN-1:0] utgt, input logic umis, input logic fl,
                      input logic et, input logic [XLEN-1:0] en, input logic [CNT_W-1:0] ec);
    vec_t v;
    v.lk = lk; v.uv = uv; v.upc = upc; v.ut = ut; v.utgt = utgt; v.umis = umis; v.fl = fl;
    v.e_taken = et; v.e_next = en; v.e_cnt = ec;
    vecs.push_back(v);
  endtask

  initial begin
    // Expected values are the outputs before the clock edge that applies the row's update.
    //    lookup        uv  upd_pc        t   target        mis fl   exp_t exp_next     cnt
    addv(32'h100,      1, 32'h100,      1, 32'h40,       1,  0,   0, 32'h104,      0); // alloc 0x100
    addv(32'h100,      0, 32'h0,        0, 32'h0,        0,  0,   1, 32'h40,       1); // hit
    addv(32'h140,      0, 32'h0,        0, 32'h0,        0,  0,   0, 32'h144,      1); // tag miss
    addv(32'h100,      1, 32'h100,      0, 32'h0,        1,  0,   1, 32'h40,       1); // WT->WNT
    addv(32'h100,      1, 32'h100,      0, 32'h0,        0,  0,   0, 32'h104,      2); // WNT->SNT
    addv(32'h100,      1, 32'h100,      1, 32'h44,       1,  0,   0, 32'h104,      2); // SNT->WNT
    addv(32'h100,      1, 32'h100,      1, 32'h48,       0,  0,   0, 32'h104,      3); // WNT->WT
    addv(32'h100,      0, 32'h0,        0, 32'h0,        0,  0,   1, 32'h48,       3);
    for (int i = 0; i < 4; i++)
      addv(32'h100,    1, 32'h100,      1, 32'h48,       0,  0,   1, 32'h48,       3); // saturate ST
    addv(32'h100,      1, 32'h100,      0, 32'h0,        0,  0,   1, 32'h48,       3); // ST->WT
    addv(32'h100,      0, 32'h100,      1, 32'hDEAD,     1,  0,   1, 32'h48,       3); // upd ignored
    addv(32'h200,      1, 32'h200,      1, 32'h80,       1,  0,   0, 32'h204,      3); // same-cycle
    addv(32'h200,      0, 32'h0,        0, 32'h0,        0,  0,   1, 32'h80,       4);
    addv(32'h100,      0, 32'h0,        0, 32'h0,        0,  0,   0, 32'h104,      4); // replaced
    addv(32'h202,      1, 32'h104,      1, 32'h10,       0,  0,   1, 32'h80,       4); // pc[1:0] ignored
    addv(32'h104,      1, 32'h108,      0, 32'h0,        0,  0,   1, 32'h10,       4); // miss NT: no alloc
    addv(32'h108,      0, 32'h0,        0, 32'h0,        0,  0,   0, 32'h10C,      4);
    addv(32'h200,      1, 32'h300,      1, 32'h90,       1,  1,   1, 32'h80,       4); // flush + upd
    addv(32'h300,      0, 32'h0,        0, 32'h0,        0,  0,   0, 32'h304,      5);
    addv(32'h100,      0, 32'h0,        0, 32'h0,        0,  0,   0, 32'h104,      5);
    addv(32'h104,      0, 32'h0,        0, 32'h0,        0,  0,   0, 32'h108,      5);
    addv(32'h200,      0, 32'h0,        0, 32'h0,        0,  0,   0, 32'h204,      5);
    addv(32'hFFFFFFFC, 0, 32'h0,        0, 32'h0,        0,  0,   0, 32'h0,        5); // +4 wraps

    // Reset state.
    rst_n = 1'b0;
    drive(32'h100, 1'b0, '0, 1'b0, '0, 1'b0, 1'b0);
    repeat (2) @(negedge clk);
    #1;
    push_exp("reset_state", 1'b0, 32'h104, '0);
    check_pop();
    @(negedge clk);
    rst_n = 1'b1;

    // Table-driven main sequence, one row per cycle.
    foreach (vecs[i]) begin
      @(negedge clk);
      drive(vecs[i].lk, vecs[i].uv, vecs[i].upc, vecs[i].ut, vecs[i].utgt, vecs[i].umis, vecs[i].fl);
      push_exp($sformatf("vec%0d", i), vecs[i].e_taken, vecs[i].e_next, vecs[i].e_cnt);
      #1;
      check_pop();
    end

    // Counter saturation: 20 mispredicts from 5 must stop at 15.
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      drive(32'h400, 1'b1, 32'h404, 1'b0, '0, 1'b1, 1'b0);
    end
    @(negedge clk);
    drive(32'h100, 1'b1, 32'h100, 1'b1, 32'h40, 1'b0, 1'b0);
    #1;
    push_exp("cnt_saturated", 1'b0, 32'h104, 4'd15);
    check_pop();
    @(negedge clk);
    drive(32'h100, 1'b0, '0, 1'b0, '0, 1'b0, 1'b0);
    #1;
    push_exp("hit_before_reset", 1'b1, 32'h40, 4'd15);
    check_pop();

    // Reset asserted mid-cycle, with an update presented: takes effect with no clock edge.
    #1;
    drive(32'h100, 1'b1, 32'h100, 1'b1, 32'h60, 1'b1, 1'b0);
    rst_n = 1'b0;
    #1;
    push_exp("async_reset", 1'b0, 32'h104, '0);
    check_pop();
    @(negedge clk);
    drive(32'h100, 1'b0, '0, 1'b0, '0, 1'b0, 1'b0);
    rst_n = 1'b1;
    #1;
    push_exp("after_reset", 1'b0, 32'h104, '0);
    check_pop();

    if (sb_q.size() != 0) begin
      n_compared++;
      n_mismatched++;
      $display("FAIL scoreboard_leftover: actual %0d pending, required 0", sb_q.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
